div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider that acts as the responder to the EX stage's divide request for DIV/DIVU. EX raises start_i with its operands and holds them while it stalls the pipeline. div_unit iterates 32 steps and returns {remainder, quotient} with ready_o. EX then writes remainder to HI and quotient to LO. annul_i lets a pipeline flush abort an in-flight divide.

---
 rtl/div_unit_pkg.sv | 23 ++
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 195 +++++++++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encoding,
// handshake levels and the operand/result bus widths.
package div_unit_pkg;

    // Operand bus and packed {remainder, quotient} result bus widths.
    localparam int DIV_OP_BUS_W     = 32;
    localparam int DIV_RESULT_BUS_W = 2 * DIV_OP_BUS_W;

    // Handshake levels on ready_o and start_i.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Divider control states.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration. The working register holds the partial
// remainder in its upper half and the shifting dividend/quotient in its lower
// half; each step tries a subtract and shifts in a quotient bit.
// Purely combinational so it can be unrolled for more bits per cycle.
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  work,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  work_next
);

    logic [DATA_W:0] diff;

    // Trial subtract of the divisor from the current partial remainder.
    assign diff = work[2*DATA_W:DATA_W] - {1'b0, divisor};

    // Restore (plain shift) on a negative trial, otherwise keep the difference.
    always_comb begin
        work_next = {work[2*DATA_W-1:0], 1'b0};
        if (!diff[DATA_W]) begin
            work_next = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider answering the EX stage's DIV/DIVU
// request. Returns {remainder, quotient} with ready_o after 32 iterations
// plus a finalize cycle; annul_i aborts a divide in flight.
// Optional macro DIV_ZERO_FLAG_EN adds the dz_o divide-by-zero flag output.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_OP_BUS_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                dz_o
`endif
);

    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

    div_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*DATA_W:0]      work_reg, work_next;
    logic [DATA_W-1:0]      divisor_reg, divisor_next;
    logic                   signed_reg, signed_next;
    logic                   neg1_reg, neg1_next;
    logic                   neg2_reg, neg2_next;
    logic [2*DATA_W-1:0]    result_reg, result_next;
    logic                   ready_reg, ready_next;
`ifdef DIV_ZERO_FLAG_EN
    logic                   zero_flag_reg, zero_flag_next;
    logic                   dz_reg, dz_next;
`endif

    logic [2*DATA_W:0]      step_work;
    logic [DATA_W-1:0]      op1_mag, op2_mag;
    logic [DATA_W-1:0]      quo_raw, rem_raw, quo_fin, rem_fin;

    // Operand magnitudes; DIVU passes operands through untouched.
    assign op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;

    // Sign correction applied once all iterations are done.
    assign quo_raw = work_reg[DATA_W-1:0];
    assign rem_raw = work_reg[2*DATA_W:DATA_W+1];
    assign quo_fin = (signed_reg && (neg1_reg ^ neg2_reg)) ? (~quo_raw + ONE) : quo_raw;
    assign rem_fin = (signed_reg && neg1_reg) ? (~rem_raw + ONE) : rem_raw;

    div_unit_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .work      (work_reg),
        .divisor   (divisor_reg),
        .work_next (step_work)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= DivFree;
            cnt_reg     <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            signed_reg  <= 1'b0;
            neg1_reg    <= 1'b0;
            neg2_reg    <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DIV_RESULT_NOT_READY;
`ifdef DIV_ZERO_FLAG_EN
            zero_flag_reg <= 1'b0;
            dz_reg        <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            signed_reg  <= signed_next;
            neg1_reg    <= neg1_next;
            neg2_reg    <= neg2_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
`ifdef DIV_ZERO_FLAG_EN
            zero_flag_reg <= zero_flag_next;
            dz_reg        <= dz_next;
`endif
        end
    end

    // Next-state and output logic for the divide sequence.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        signed_next  = signed_reg;
        neg1_next    = neg1_reg;
        neg2_next    = neg2_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
`ifdef DIV_ZERO_FLAG_EN
        zero_flag_next = zero_flag_reg;
        dz_next        = dz_reg;
`endif

        case (state_reg)
            DivFree: begin
                ready_next  = DIV_RESULT_NOT_READY;
                result_next = '0;
`ifdef DIV_ZERO_FLAG_EN
                dz_next        = 1'b0;
                zero_flag_next = 1'b0;
`endif
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next   = DivOn;
                        cnt_next     = '0;
                        divisor_next = op2_mag;
                        work_next    = {{DATA_W{1'b0}}, op1_mag, 1'b0};
                        signed_next  = signed_div_i;
                        neg1_next    = opdata1_i[DATA_W-1];
                        neg2_next    = opdata2_i[DATA_W-1];
                    end
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    // Zero result; also marks the zero divisor for the flag.
                    work_next  = '0;
                    state_next = DivEnd;
`ifdef DIV_ZERO_FLAG_EN
                    zero_flag_next = 1'b1;
`endif
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt_reg != CNT_LAST) begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + CNT_ONE;
                end else begin
                    // Repack the signed-corrected result into the working register;
                    // DivEnd presents it on the following edge.
                    work_next  = {rem_fin, 1'b0, quo_fin};
                    cnt_next   = '0;
                    state_next = DivEnd;
                end
            end

            DivEnd: begin
                if (start_i == DIV_START) begin
                    result_next = {rem_raw, quo_raw};
                    ready_next  = DIV_RESULT_READY;
`ifdef DIV_ZERO_FLAG_EN
                    dz_next = zero_flag_reg;
`endif
                end else begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
`ifdef DIV_ZERO_FLAG_EN
                    dz_next = 1'b0;
`endif
                end
            end

            default: begin
                state_next = DivFree;
            end
        endcase
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;
`ifdef DIV_ZERO_FLAG_EN
    assign dz_o = dz_reg;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (annul, reset mid-divide, operand change) and random vectors
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;
`ifdef DIV_ZERO_FLAG_EN
    logic        dz;
`endif

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz_o         (dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Reference model: plain integer division, truncating toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Drive a request; returns #1 after the edge T that samples it.
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk); #1;
    endtask

    // Wait for ready_o (bounded), check latency, result, hold and release.
    task automatic wait_ready(input string nm, input logic [63:0] exp, input int exp_lat,
                              input int skip, input bit exp_dz);
        int lat;
        lat = -1;
        for (int k = skip + 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = k;
                break;
            end
        end
        $display("%s: sgn=%0d a=%h b=%h latency=%0d result=%h", nm, signed_div, op1, op2, lat, result);
        chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, ".result"}, result, exp);
`ifdef DIV_ZERO_FLAG_EN
        chk({nm, ".dz"}, {63'h0, dz}, {63'h0, exp_dz});
`else
        if (exp_dz) begin end
`endif
        @(posedge clk); #1;
        chk({nm, ".hold_ready"}, {63'h0, ready}, 64'h1);
        chk({nm, ".hold_result"}, result, exp);
        start = 1'b0;
        @(posedge clk); #1;
        chk({nm, ".drop_ready"}, {63'h0, ready}, 64'h0);
        chk({nm, ".drop_result"}, result, 64'h0);
    endtask

    initial begin
        rst = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 34};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'h00000007, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, {32'h00000002, 32'hFFFFFFF2}, 34};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, {32'h00000000, 32'hFFFFFFFF}, 34};
        vecs[5] = '{1'b0, 32'h12345678,   32'h00000000, 64'h0,                        2};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 34};
        vecs[7] = '{1'b0, 32'h00000005,   32'h00000009, {32'h00000005, 32'h00000000}, 34};

        repeat (3) @(posedge clk);
        #1;
        $display("reset: ready=%0d result=%h", ready, result);
        chk("reset.ready", {63'h0, ready}, 64'h0);
        chk("reset.result", result, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_ready($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, 0, vecs[i].b == 32'h0);
        end

        // Annul at iteration 10, then an immediate DIVU 9/3.
        issue(1'b0, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        op1   = 32'd9;
        op2   = 32'd3;
        @(posedge clk); #1;
        annul = 1'b0;
        $display("annul: ready=%0d", ready);
        chk("annul.ready", {63'h0, ready}, 64'h0);
        @(posedge clk); #1;
        wait_ready("annul_restart", {32'h0, 32'h3}, 34, 0, 1'b0);

        // Reset at iteration 20.
        issue(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("midreset: ready=%0d result=%h", ready, result);
        chk("midreset.ready", {63'h0, ready}, 64'h0);
        chk("midreset.result", result, 64'h0);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset.idle_ready", {63'h0, ready}, 64'h0);

        // Operands change after the start is sampled.
        issue(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        op1 = 32'hDEADBEEF; op2 = 32'd0; signed_div = 1'b1;
        wait_ready("opchange", {32'h2, 32'hE}, 34, 5, 1'b0);

        // Randomized against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            bit s;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            s = 1'($urandom_range(0, 1));
            issue(s, a, b);
            wait_ready($sformatf("rnd%0d", i), ref_div(s, a, b), (b == 32'h0) ? 2 : 34, 0, b == 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
